dmem_arbiter: RTL

- Shares the single-port, word-addressed data memory between two requesters: the pipeline MEM stage (cpu port) and the program/data loader (ext port).
- Grants one access per cycle. The cpu port has priority, bounded by a starvation counter that protects the ext port.
- Routes 1-cycle-latency read data back to whichever port owns the access.
- Flags misaligned and out-of-range accesses instead of issuing them to the memory.

---
 rtl/dmem_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: cpu has priority, ext is
// protected by a starvation counter, and bad accesses become error responses.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_AW     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_err,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [AW-1:0]     ext_addr,
  input  logic [DW-1:0]     ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DW-1:0]     ext_rdata,
  output logic              ext_err,

  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          r_rsp_valid;
  logic          r_rsp_owner_ext;
  logic          r_rsp_err;

  logic          w_ext_force;
  logic          w_gnt_any;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_bad;

  assign w_ext_force = ext_req && (r_starve_cnt == CW'(STARVE_MAX));
  assign ext_gnt     = ext_req && (w_ext_force || !cpu_req);
  assign cpu_gnt     = cpu_req && !w_ext_force;
  assign w_gnt_any   = cpu_gnt || ext_gnt;
  assign cpu_stall   = cpu_req && !cpu_gnt;

  // Mux defaults to the cpu side when idle so mem_addr tracks the pipeline.
  assign w_addr  = ext_gnt ? ext_addr  : cpu_addr;
  assign w_we    = ext_gnt ? ext_we    : cpu_we;
  assign w_wdata = ext_gnt ? ext_wdata : cpu_wdata;

  assign w_bad = (w_addr[1:0] != 2'b00) || (w_addr[AW-1:MEM_AW+2] != '0);

  assign mem_en    = w_gnt_any && !w_bad;
  assign mem_we    = w_we && mem_en;
  assign mem_addr  = w_addr[MEM_AW+1:2];
  assign mem_wdata = w_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt    <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_owner_ext <= 1'b0;
      r_rsp_err       <= 1'b0;
    end else begin
      if (!ext_req || ext_gnt) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != CW'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
      // Bad stores still answer so the requester sees the error.
      r_rsp_valid     <= w_gnt_any && (!w_we || w_bad);
      r_rsp_owner_ext <= ext_gnt;
      r_rsp_err       <= w_bad;
    end
  end

  assign cpu_rvalid = r_rsp_valid && !r_rsp_owner_ext;
  assign ext_rvalid = r_rsp_valid && r_rsp_owner_ext;
  assign cpu_err    = cpu_rvalid && r_rsp_err;
  assign ext_err    = ext_rvalid && r_rsp_err;
  assign cpu_rdata  = (cpu_rvalid && !r_rsp_err) ? mem_rdata : '0;
  assign ext_rdata  = (ext_rvalid && !r_rsp_err) ? mem_rdata : '0;

endmodule
